// File: rtl/pattern_player.sv
// pattern_player: replays a RAM table of {time,data} entries onto stim_data at
// exact cycles of a playback timer, with looping and sticky order-error capture.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; RAM writable
// FETCH0  | read of entry 0 issued
// FETCH1  | entry 0 on RAM output, read of entry 1 issued
// RUN     | timer counting, entries applied or skipped one per cycle max
// DONE    | non-loop pass complete; RAM writable
module pattern_player #(
    parameter int DATA_W    = 40,
    parameter int TIME_W    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [TIME_W-1:0] load_time,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] last_index,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] stim_data,
    output logic              stim_valid,
    output logic              busy,
    output logic              done,
    output logic              order_err,
    output logic [ADDR_W-1:0] err_index,
    output logic [TIME_W-1:0] timer
);

    localparam int ENT_W = TIME_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rdata;
    logic [ENT_W-1:0]  cur;
    logic [ENT_W-1:0]  head;
    logic [TIME_W-1:0] head_time;
    logic [DATA_W-1:0] head_data;
    logic [TIME_W-1:0] t_next;
    logic [TIME_W-1:0] prev_time;
    logic [ADDR_W-1:0] head_idx;
    logic [ADDR_W-1:0] last_r;
    logic [ADDR_W-1:0] rd_addr;
    logic              use_rd;
    logic              loop_r;
    logic              final_hit;
    logic              have_prev;
    logic              live;
    logic              skip;
    logic              apply;
    logic              handled;
    logic              go;

    // Pattern RAM write port; table is frozen while a pass is in flight.
    always_ff @(posedge clk) begin
        if (load_en && (state == S_IDLE || state == S_DONE))
            mem[load_addr] <= {load_time, load_data};
    end

    // Pattern RAM synchronous read port.
    always_ff @(posedge clk) begin
        rdata <= mem[rd_addr];
    end

    // Head entry selection and apply/skip decision for the coming RUN cycle.
    // The head is either still on the RAM output (use_rd) or parked in cur;
    // deciding one edge early lets stim_data/stim_valid stay registered.
    always_comb begin
        head      = use_rd ? rdata : cur;
        head_time = head[ENT_W-1 -: TIME_W];
        head_data = head[DATA_W-1:0];
        t_next    = (state == S_FETCH1) ? '0 : timer + TIME_W'(1);
        live      = (state == S_FETCH1) || (state == S_RUN && !final_hit);
        skip      = live && ((head_time < t_next) ||
                             (have_prev && head_time <= prev_time));
        apply     = live && !skip && (head_time == t_next);
        handled   = skip || apply;
        go        = start && !stop;
        rd_addr   = '0;
        if (state == S_FETCH1 || state == S_RUN)
            rd_addr = (use_rd || !handled) ? head_idx + ADDR_W'(1)
                                           : head_idx + ADDR_W'(2);
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            stim_data  <= '0;
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            order_err  <= 1'b0;
            err_index  <= '0;
            timer      <= '0;
            cur        <= '0;
            prev_time  <= '0;
            head_idx   <= '0;
            last_r     <= '0;
            use_rd     <= 1'b1;
            loop_r     <= 1'b0;
            final_hit  <= 1'b0;
            have_prev  <= 1'b0;
        end else begin
            stim_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state     <= S_FETCH0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        order_err <= 1'b0;
                        if (state == S_IDLE) err_index <= '0;
                        timer     <= '0;
                        have_prev <= 1'b0;
                        use_rd    <= 1'b1;
                        head_idx  <= '0;
                        final_hit <= 1'b0;
                        last_r    <= last_index;
                        loop_r    <= loop_en;
                    end
                end
                S_FETCH0: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_FETCH1;
                    end
                end
                S_FETCH1, S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (state == S_RUN && final_hit) begin
                        final_hit <= 1'b0;
                        if (loop_r) begin
                            state     <= S_FETCH0;
                            timer     <= '0;
                            have_prev <= 1'b0;
                            use_rd    <= 1'b1;
                            head_idx  <= '0;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        if (state == S_FETCH1) begin
                            state <= S_RUN;
                            timer <= '0;
                        end else begin
                            timer <= timer + TIME_W'(1);
                        end
                        if (use_rd ^ handled) cur <= rdata;
                        use_rd <= use_rd & handled;
                        if (handled) begin
                            head_idx <= head_idx + ADDR_W'(1);
                            if (head_idx == last_r) final_hit <= 1'b1;
                        end
                        if (apply) begin
                            stim_data  <= head_data;
                            stim_valid <= 1'b1;
                            prev_time  <= head_time;
                            have_prev  <= 1'b1;
                        end
                        if (skip) begin
                            order_err <= 1'b1;
                            if (!order_err) err_index <= head_idx;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_player.sv
// Testbench for pattern_player: table-driven and randomized playback checked
// against a timeline model derived from the apply/skip rules.
module tb_pattern_player;

    localparam int DATA_W = 40;
    localparam int TIME_W = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [TIME_W-1:0] load_time = '0;
    logic [DATA_W-1:0] load_data = '0;
    logic [ADDR_W-1:0] last_index = '0;
    logic              loop_en = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [DATA_W-1:0] stim_data;
    logic              stim_valid;
    logic              busy;
    logic              done;
    logic              order_err;
    logic [ADDR_W-1:0] err_index;
    logic [TIME_W-1:0] timer;

    pattern_player #(.DATA_W(DATA_W), .TIME_W(TIME_W), .DEPTH(256), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_time(load_time), .load_data(load_data), .last_index(last_index),
        .loop_en(loop_en), .start(start), .stop(stop), .stim_data(stim_data),
        .stim_valid(stim_valid), .busy(busy), .done(done), .order_err(order_err),
        .err_index(err_index), .timer(timer)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observation log: every stim_valid cycle and every rising edge of done.
    int                mon_cyc[$];
    logic [DATA_W-1:0] mon_data[$];
    int                done_rise[$];
    logic              prev_done = 1'b0;
    always @(negedge clk) begin
        if (stim_valid) begin
            mon_cyc.push_back(cyc);
            mon_data.push_back(stim_data);
        end
        if (done && !prev_done) done_rise.push_back(cyc);
        prev_done = done;
    end

    int                tbl_t[32];
    logic [DATA_W-1:0] tbl_d[32];
    int                tbl_n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < tbl_n; i++) begin
            load_en   = 1'b1;
            load_addr = ADDR_W'(i);
            load_time = TIME_W'(tbl_t[i]);
            load_data = tbl_d[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    // One non-loop pass of the loaded table, checked against the timeline model.
    task automatic play_check(input string name, input bit poke);
        int exp_rel[$];
        logic [DATA_W-1:0] exp_dat[$];
        int pos, prev, first_skip, final_rel, k, mb, db, got;
        pos = 0; prev = -1; first_skip = -1; final_rel = 0;
        for (int j = 0; j < tbl_n; j++) begin
            if (tbl_t[j] >= pos && tbl_t[j] > prev) begin
                exp_rel.push_back(tbl_t[j]);
                exp_dat.push_back(tbl_d[j]);
                prev = tbl_t[j];
                final_rel = tbl_t[j];
                pos = tbl_t[j] + 1;
            end else begin
                if (first_skip < 0) first_skip = j;
                final_rel = pos;
                pos = pos + 1;
            end
        end
        mb = mon_cyc.size();
        db = done_rise.size();
        last_index = ADDR_W'(tbl_n - 1);
        loop_en = 1'b0;
        start = 1'b1;
        k = cyc;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %0b want 1", name, busy);
        end
        if (poke) begin
            tick(); tick();
            load_en = 1'b1; load_addr = '0; load_time = '0; load_data = 40'h55;
            tick();
            load_en = 1'b0;
        end
        while (done_rise.size() == db && cyc < k + final_rel + 20) tick();
        tick(); tick();
        checks++;
        if (done_rise.size() == db) begin
            errors++;
            $display("FAIL %s done_timeout got none want cycle %0d", name, k + final_rel + 4);
        end else if (done_rise[db] !== k + final_rel + 4) begin
            errors++;
            $display("FAIL %s done_cycle got %0d want %0d", name, done_rise[db] - k, final_rel + 4);
        end
        got = mon_cyc.size() - mb;
        checks++;
        if (got !== exp_rel.size()) begin
            errors++;
            $display("FAIL %s apply_count got %0d want %0d", name, got, exp_rel.size());
        end
        for (int i = 0; i < exp_rel.size() && i < got; i++) begin
            checks++;
            if (mon_cyc[mb+i] !== k + 3 + exp_rel[i] || mon_data[mb+i] !== exp_dat[i]) begin
                errors++;
                $display("FAIL %s apply%0d got cyc+%0d data %h want cyc+%0d data %h", name, i,
                         mon_cyc[mb+i] - k, mon_data[mb+i], 3 + exp_rel[i], exp_dat[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s end_flags got busy %0b done %0b want 0 1", name, busy, done);
        end
        checks++;
        if (order_err !== (first_skip >= 0)) begin
            errors++;
            $display("FAIL %s order_err got %0b want %0b", name, order_err, first_skip >= 0);
        end
        if (first_skip >= 0) begin
            checks++;
            if (err_index !== ADDR_W'(first_skip)) begin
                errors++;
                $display("FAIL %s err_index got %0d want %0d", name, err_index, first_skip);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        checks++;
        if (stim_data !== '0 || stim_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            order_err !== 1'b0 || err_index !== '0 || timer !== '0) begin
            errors++;
            $display("FAIL reset_values got data %h v %0b busy %0b done %0b err %0b idx %0d timer %0d want all 0",
                     stim_data, stim_valid, busy, done, order_err, err_index, timer);
        end
    endtask

    task automatic test_basic();
        tbl_n = 3;
        tbl_t[0] = 3; tbl_d[0] = 40'hA5;
        tbl_t[1] = 7; tbl_d[1] = 40'h3C;
        tbl_t[2] = 8; tbl_d[2] = 40'hFF;
        load_table();
        play_check("basic", 1'b0);
    endtask

    task automatic test_out_of_order();
        tbl_n = 3;
        tbl_t[0] = 5; tbl_d[0] = 40'h01;
        tbl_t[1] = 4; tbl_d[1] = 40'h02;
        tbl_t[2] = 9; tbl_d[2] = 40'h03;
        load_table();
        play_check("ooo_5_4_9", 1'b0);
        tbl_n = 2;
        tbl_t[0] = 5; tbl_d[0] = 40'h11;
        tbl_t[1] = 5; tbl_d[1] = 40'h22;
        load_table();
        play_check("ooo_equal", 1'b0);
    endtask

    task automatic test_back_to_back();
        tbl_n = 16;
        for (int i = 0; i < 16; i++) begin
            tbl_t[i] = i;
            tbl_d[i] = DATA_W'(40'hC0DE000000 + i * 7);
        end
        load_table();
        play_check("back_to_back", 1'b0);
        tbl_n = 1;
        tbl_t[0] = 0; tbl_d[0] = 40'h9876543210;
        load_table();
        play_check("single_t0", 1'b0);
    endtask

    task automatic test_random();
        int t;
        for (int r = 0; r < 6; r++) begin
            tbl_n = $urandom_range(12, 1);
            t = $urandom_range(3, 0);
            for (int i = 0; i < tbl_n; i++) begin
                if (i > 0) begin
                    if ($urandom_range(4, 0) == 0) tbl_t[i] = $urandom_range(t, 0);
                    else begin
                        t = t + $urandom_range(4, 1);
                        tbl_t[i] = t;
                    end
                end else tbl_t[i] = t;
                tbl_d[i] = DATA_W'({$urandom(), $urandom()});
            end
            load_table();
            play_check($sformatf("random%0d", r), 1'b0);
        end
    endtask

    task automatic test_load_guard();
        tbl_n = 1;
        tbl_t[0] = 5; tbl_d[0] = 40'hAA;
        load_table();
        play_check("guard_first", 1'b0);
        play_check("guard_poke", 1'b1);
        play_check("guard_replay", 1'b0);
        tbl_d[0] = 40'h77;
        load_table();
        play_check("guard_new", 1'b0);
    endtask

    task automatic test_loop();
        int k, mb, db, n_exp;
        tbl_n = 2;
        tbl_t[0] = 0; tbl_d[0] = 40'hD0;
        tbl_t[1] = 2; tbl_d[1] = 40'hD2;
        load_table();
        mb = mon_cyc.size();
        db = done_rise.size();
        last_index = 8'd1;
        loop_en = 1'b1;
        start = 1'b1;
        k = cyc;
        tick();
        start = 1'b0;
        loop_en = 1'b0;
        while (cyc < k + 18) begin
            tick();
            if (cyc == k + 8) begin
                checks++;
                if (timer !== '0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL loop_restart_timer got timer %0d busy %0b want 0 1", timer, busy);
                end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick(); tick();
        n_exp = 0;
        for (int p = 0; p < 4; p++) begin
            for (int e = 0; e < 2; e++) begin
                if (k + 3 + 5 * p + 2 * e <= k + 18) begin
                    checks++;
                    if (mon_cyc.size() <= mb + n_exp) begin
                        errors++;
                        $display("FAIL loop_apply%0d got none want cyc+%0d", n_exp, 3 + 5 * p + 2 * e);
                    end else if (mon_cyc[mb+n_exp] !== k + 3 + 5 * p + 2 * e ||
                                 mon_data[mb+n_exp] !== tbl_d[e]) begin
                        errors++;
                        $display("FAIL loop_apply%0d got cyc+%0d data %h want cyc+%0d data %h", n_exp,
                                 mon_cyc[mb+n_exp] - k, mon_data[mb+n_exp], 3 + 5 * p + 2 * e, tbl_d[e]);
                    end
                    n_exp++;
                end
            end
        end
        checks++;
        if (mon_cyc.size() - mb !== n_exp) begin
            errors++;
            $display("FAIL loop_apply_count got %0d want %0d", mon_cyc.size() - mb, n_exp);
        end
        checks++;
        if (done_rise.size() !== db || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_flags got done_rises %0d busy %0b want 0 0", done_rise.size() - db, busy);
        end
    endtask

    task automatic test_abort();
        int k, mb;
        tbl_n = 2;
        tbl_t[0] = 2; tbl_d[0] = 40'h11;
        tbl_t[1] = 6; tbl_d[1] = 40'h22;
        load_table();
        mb = mon_cyc.size();
        last_index = 8'd1;
        start = 1'b1;
        k = cyc;
        tick();
        start = 1'b0;
        while (cyc < k + 7) tick();
        checks++;
        if (timer !== 32'd4) begin
            errors++;
            $display("FAIL abort_timer_before_stop got %0d want 4", timer);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %0b want 0", busy);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (mon_cyc.size() - mb !== 1 || stim_data !== 40'h11 || timer !== 32'd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold got applies %0d data %h timer %0d done %0b want 1 11 4 0",
                     mon_cyc.size() - mb, stim_data, timer, done);
        end
        // Mid-run reset after a skip has made order_err sticky.
        tbl_n = 3;
        tbl_t[0] = 5; tbl_d[0] = 40'h01;
        tbl_t[1] = 4; tbl_d[1] = 40'h02;
        tbl_t[2] = 9; tbl_d[2] = 40'h03;
        load_table();
        last_index = 8'd2;
        start = 1'b1;
        k = cyc;
        tick();
        start = 1'b0;
        while (cyc < k + 11) tick();
        checks++;
        if (order_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_precondition got err %0b busy %0b want 1 1", order_err, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (stim_data !== '0 || stim_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            order_err !== 1'b0 || err_index !== '0 || timer !== '0) begin
            errors++;
            $display("FAIL rst_midrun got data %h v %0b busy %0b done %0b err %0b idx %0d timer %0d want all 0",
                     stim_data, stim_valid, busy, done, order_err, err_index, timer);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_order();
        test_back_to_back();
        test_random();
        test_load_guard();
        test_loop();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
